game_stage_ctrl: RTL and testbench
==================================

Name: game_stage_ctrl

Overview:
- Game-flow controller that produces the one-hot stage levels start_l, battle_l, win_l and lose_l consumed by color_mapper.
- Tracks player and NPC hit points from hit pulses and detects the start key.
- Commits stage changes only on frame boundaries, so a displayed frame never mixes two stages.
- Sits between the input/collision logic and the colour mapper.

Parameters:
- MAX_HP, 8: hit points loaded into both counters on entry to BATTLE.
- HP_W, 4: width of the HP counters; must satisfy MAX_HP < 2**HP_W.
- HOLD_FRAMES, 180: number of frames the WIN or LOSE screen is held before returning to START.
- HOLD_W, 8: width of the hold-frame counter; must satisfy HOLD_FRAMES < 2**HOLD_W.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse in the Clk domain, asserted once per frame at vertical blank.
- start_key  in  1  start button level, already synchronised to Clk.
- player_hit  in  1  single-cycle pulse: the projectile struck the player.
- npc_hit  in  1  single-cycle pulse: the player struck the NPC.
- start_l  out  1  START stage active.
- battle_l  out  1  BATTLE stage active.
- win_l  out  1  WIN stage active.
- lose_l  out  1  LOSE stage active.
- player_hp  out  HP_W  current player hit points.
- npc_hp  out  HP_W  current NPC hit points.
- stage_change  out  1  single-cycle pulse on the cycle the stage outputs take a new value.

Behaviour:
- Reset (async, Reset_n=0):
  - state=START; start_l=1; battle_l, win_l, lose_l = 0.
  - player_hp = npc_hp = MAX_HP.
  - hold counter = 0; start_req = 0; stage_change = 0; start_key history register = 0.
  - Reset mid-battle returns to START immediately, without waiting for a frame boundary.
- Stage outputs:
  - Registered and decoded from state; exactly one of the four is high in every cycle.
- States and transitions:
  - All transitions are evaluated only in a cycle where frame_start=1.
  - The new state and outputs are visible in the next cycle, so latency is 1 Clk after frame_start.
  - stage_change pulses in that same cycle.
  - START: on frame_start with start_req=1, go to BATTLE and clear start_req.
  - BATTLE: on frame_start, if player_hp==0 go to LOSE. Otherwise, if npc_hp==0 go to WIN.
  - If both HPs are 0, LOSE takes priority.
  - WIN / LOSE: the hold counter increments on each frame_start. When the counter equals HOLD_FRAMES-1 at a frame_start, go to START and clear the counter.
  - The counter is cleared on entry to WIN or LOSE.
- Start key handling:
  - A rising edge of start_key (current=1, previous=0) sets start_req, but only while state=START. Edges in any other state are discarded.
  - Holding start_key high does not re-trigger; a fresh 0->1 edge is required.
  - An edge arriving in the same cycle as frame_start is latched and acted on at the next frame_start, not the current one.
- HP counters:
  - Reloaded to MAX_HP on the cycle of the START->BATTLE commit.
  - In BATTLE, each hit pulse decrements its counter by 1 in the following cycle, saturating at 0 (no wrap).
  - player_hit and npc_hit in the same cycle both decrement.
  - Hits are ignored outside BATTLE, so counters hold their value through WIN/LOSE for display.
  - A hit in the same cycle as the BATTLE->WIN/LOSE commit is ignored.
- Hit pulses:
  - Are not frame-aligned; HP changes take effect mid-frame.
  - Only the stage outputs are frame-aligned.

Decomposition:
- Shared package game_pkg:
  - stage_t enum {STAGE_START, STAGE_BATTLE, STAGE_WIN, STAGE_LOSE} (2-bit).
  - Default constants MAX_HP_DEF and HOLD_FRAMES_DEF.
- Sub-module hp_counter, instantiated twice:
  - Inputs: Clk, Reset_n, load, dec, en.
  - Behaviour: load to MAX_HP, saturating decrement.
  - Output: hp.

Test Plan:
- Reset asserted mid-cycle with the FSM in BATTLE -> outputs go immediately to start_l=1, others 0, player_hp=npc_hp=8, stage_change=0.
- In START, raise start_key, then pulse frame_start 5 cycles later -> battle_l=1 exactly 1 cycle after frame_start. stage_change pulses once. Both HPs read 8.
- In BATTLE, issue 8 npc_hit pulses, then 2 extra pulses -> npc_hp steps 8..0 and stays at 0. The next frame_start gives win_l=1 one cycle later.
- In BATTLE with player_hp=1 and npc_hp=1, player_hit and npc_hit in the same cycle -> both HPs become 0; the next frame_start selects lose_l=1 (LOSE priority).
- Enter WIN with HOLD_FRAMES=3 -> win_l stays high through 2 frame_starts, then start_l=1 one cycle after the 3rd. A start_key edge during WIN leaves start_req=0.
- Hold start_key high across entry to START -> no BATTLE transition. Release, re-press and pulse frame_start -> BATTLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared stage encoding and default sizing for the game-flow controller.
package game_pkg;

    typedef enum logic [1:0] {
        STAGE_START  = 2'd0,
        STAGE_BATTLE = 2'd1,
        STAGE_WIN    = 2'd2,
        STAGE_LOSE   = 2'd3
    } stage_t;

    localparam int MAX_HP_DEF      = 8;
    localparam int HP_W_DEF        = 4;
    localparam int HOLD_FRAMES_DEF = 180;
    localparam int HOLD_W_DEF      = 8;

    // Bit order {start, battle, win, lose}.
    function automatic logic [3:0] stage_onehot(input stage_t s);
        logic [3:0] oh;
        oh = 4'b0000;
        case (s)
            STAGE_START:  oh = 4'b1000;
            STAGE_BATTLE: oh = 4'b0100;
            STAGE_WIN:    oh = 4'b0010;
            STAGE_LOSE:   oh = 4'b0001;
            default:      oh = 4'b1000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/game_stage_ctrl_hp_counter.sv
// Hit-point counter: reload to MAX_HP, saturating decrement on enabled hits.
module hp_counter #(
    parameter int MAX_HP = 8,
    parameter int HP_W   = 4
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            load,
    input  logic            dec,
    input  logic            en,
    output logic [HP_W-1:0] hp
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hp <= HP_W'(MAX_HP);
        end else if (load) begin
            hp <= HP_W'(MAX_HP);
        end else if (en && dec && (hp != '0)) begin
            hp <= hp - HP_W'(1);
        end
    end

endmodule

// File: rtl/game_stage_ctrl.sv
// Game-flow controller: frame-aligned stage sequencing plus player/NPC hit points.
//
// state        | meaning
// -------------+----------------------------------------------------------
// STAGE_START  | title screen, waiting for a latched start-key edge
// STAGE_BATTLE | play in progress, hits decrement HP
// STAGE_WIN    | NPC defeated, held for HOLD_FRAMES frames
// STAGE_LOSE   | player defeated, held for HOLD_FRAMES frames
module game_stage_ctrl
    import game_pkg::*;
#(
    parameter int MAX_HP      = MAX_HP_DEF,
    parameter int HP_W        = HP_W_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
    parameter int HOLD_W      = HOLD_W_DEF
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            frame_start,
    input  logic            start_key,
    input  logic            player_hit,
    input  logic            npc_hit,
    output logic            start_l,
    output logic            battle_l,
    output logic            win_l,
    output logic            lose_l,
    output logic [HP_W-1:0] player_hp,
    output logic [HP_W-1:0] npc_hp,
    output logic            stage_change
);

    stage_t            state;
    stage_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              start_req;
    logic              start_key_q;
    logic              key_rise;
    logic              in_hold;
    logic              commit_battle;
    logic              leave_battle;
    logic              hold_done;
    logic              hit_en;

    assign key_rise      = start_key & ~start_key_q;
    assign in_hold       = (state == STAGE_WIN) || (state == STAGE_LOSE);
    assign commit_battle = (state == STAGE_START) && frame_start && start_req;
    assign leave_battle  = (state == STAGE_BATTLE) && frame_start &&
                           ((player_hp == '0) || (npc_hp == '0));
    assign hold_done     = in_hold && frame_start &&
                           (hold_cnt == HOLD_W'(HOLD_FRAMES - 1));
    // Hits landing on the commit cycle are dropped so the final HP matches the verdict.
    assign hit_en        = (state == STAGE_BATTLE) && !leave_battle;

    always_comb begin
        state_nxt = state;
        case (state)
            STAGE_START: begin
                if (commit_battle) state_nxt = STAGE_BATTLE;
            end
            STAGE_BATTLE: begin
                if (leave_battle) begin
                    state_nxt = (player_hp == '0) ? STAGE_LOSE : STAGE_WIN;
                end
            end
            STAGE_WIN, STAGE_LOSE: begin
                if (hold_done) state_nxt = STAGE_START;
            end
            default: state_nxt = STAGE_START;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= STAGE_START;
            {start_l, battle_l, win_l, lose_l} <= 4'b1000;
            stage_change <= 1'b0;
            start_key_q  <= 1'b0;
            start_req    <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            {start_l, battle_l, win_l, lose_l} <= stage_onehot(state_nxt);
            stage_change <= (state_nxt != state);
            start_key_q  <= start_key;

            // A same-cycle edge is only latched here, so it waits for the next frame.
            if (commit_battle) begin
                start_req <= 1'b0;
            end else if ((state == STAGE_START) && key_rise) begin
                start_req <= 1'b1;
            end

            if (state_nxt != state) begin
                hold_cnt <= '0;
            end else if (in_hold && frame_start) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    hp_counter #(
        .MAX_HP (MAX_HP),
        .HP_W   (HP_W)
    ) u_player_hp (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (commit_battle),
        .dec     (player_hit),
        .en      (hit_en),
        .hp      (player_hp)
    );

    hp_counter #(
        .MAX_HP (MAX_HP),
        .HP_W   (HP_W)
    ) u_npc_hp (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (commit_battle),
        .dec     (npc_hit),
        .en      (hit_en),
        .hp      (npc_hp)
    );

endmodule

// File: tb/tb_game_stage_ctrl.sv
// Table-driven bench for game_stage_ctrl with a one-cycle scoreboard queue.
module tb_game_stage_ctrl;

    localparam logic [3:0] S = 4'b1000;
    localparam logic [3:0] B = 4'b0100;
    localparam logic [3:0] W = 4'b0010;
    localparam logic [3:0] L = 4'b0001;

    typedef struct {
        logic       fs;
        logic       sk;
        logic       ph;
        logic       nh;
        logic [3:0] stage;
        logic [3:0] php;
        logic [3:0] nhp;
        logic       chg;
    } vec_t;

    logic       Clk;
    logic       Reset_n;
    logic       frame_start;
    logic       start_key;
    logic       player_hit;
    logic       npc_hit;
    logic       start_l;
    logic       battle_l;
    logic       win_l;
    logic       lose_l;
    logic [3:0] player_hp;
    logic [3:0] npc_hp;
    logic       stage_change;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    game_stage_ctrl #(
        .MAX_HP      (8),
        .HP_W        (4),
        .HOLD_FRAMES (3),
        .HOLD_W      (8)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (frame_start),
        .start_key    (start_key),
        .player_hit   (player_hit),
        .npc_hit      (npc_hit),
        .start_l      (start_l),
        .battle_l     (battle_l),
        .win_l        (win_l),
        .lose_l       (lose_l),
        .player_hp    (player_hp),
        .npc_hp       (npc_hp),
        .stage_change (stage_change)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic add(input logic fs, input logic sk, input logic ph, input logic nh,
                       input logic [3:0] stage, input logic [3:0] php,
                       input logic [3:0] nhp, input logic chg);
        vec_t v;
        v.fs = fs; v.sk = sk; v.ph = ph; v.nh = nh;
        v.stage = stage; v.php = php; v.nhp = nhp; v.chg = chg;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] got,
                       input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, got, want);
        end
    endtask

    task automatic check_outputs(input int idx, input vec_t e);
        chk("stage", idx, {start_l, battle_l, win_l, lose_l}, e.stage);
        chk("player_hp", idx, player_hp, e.php);
        chk("npc_hp", idx, npc_hp, e.nhp);
        chk("stage_change", idx, {3'b000, stage_change}, {3'b000, e.chg});
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        frame_start = v.fs;
        start_key   = v.sk;
        player_hit  = v.ph;
        npc_hit     = v.nh;
        exp_q.push_back(v);
        @(posedge Clk);
        @(negedge Clk);
        e = exp_q.pop_front();
        check_outputs(idx, e);
    endtask

    initial begin
        vec_t rv;
        Reset_n = 1'b0;
        frame_start = 1'b0; start_key = 1'b0; player_hit = 1'b0; npc_hit = 1'b0;

        // fs sk ph nh | stage php nhp chg
        add(0,0,0,0, S,8,8,0);
        add(0,1,0,0, S,8,8,0);
        add(0,1,0,0, S,8,8,0);
        add(0,1,0,0, S,8,8,0);
        add(0,1,0,0, S,8,8,0);
        add(0,1,0,0, S,8,8,0);
        add(1,1,0,0, B,8,8,1);
        add(0,1,0,0, B,8,8,0);
        for (int i = 7; i >= 0; i--) add(0,0,0,1, B,8,4'(i),0);
        add(0,0,0,1, B,8,0,0);
        add(0,0,0,1, B,8,0,0);
        add(0,1,0,0, B,8,0,0);
        add(1,0,0,0, W,8,0,1);
        add(0,0,1,1, W,8,0,0);
        add(0,0,0,0, W,8,0,0);
        add(0,1,0,0, W,8,0,0);
        add(1,1,0,0, W,8,0,0);
        add(1,0,0,0, W,8,0,0);
        add(0,0,0,0, W,8,0,0);
        add(1,0,0,0, S,8,0,1);
        add(1,0,0,0, S,8,0,0);
        add(0,1,0,0, S,8,0,0);
        add(1,1,0,0, B,8,8,1);
        for (int i = 7; i >= 0; i--) add(0,1,1,1, B,4'(i),4'(i),0);
        add(1,1,0,0, L,0,0,1);
        add(1,1,0,0, L,0,0,0);
        add(1,1,0,0, L,0,0,0);
        add(1,1,0,0, S,0,0,1);
        add(1,1,0,0, S,0,0,0);
        add(0,1,0,0, S,0,0,0);
        add(0,0,0,0, S,0,0,0);
        add(1,1,0,0, S,0,0,0);
        add(1,1,0,0, B,8,8,1);
        add(1,0,1,0, B,7,8,0);
        for (int i = 6; i >= 0; i--) add(0,0,1,0, B,4'(i),8,0);
        add(1,0,0,1, L,0,8,1);
        add(1,0,0,0, L,0,8,0);
        add(1,0,0,0, L,0,8,0);
        add(1,0,0,0, S,0,8,1);
        add(0,1,0,0, S,0,8,0);
        add(1,0,0,0, B,8,8,1);
        add(0,0,1,0, B,7,8,0);

        #12;
        rv.stage = S; rv.php = 8; rv.nhp = 8; rv.chg = 0;
        check_outputs(-1, rv);
        Reset_n = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
            checks++;
            if ($countones({start_l, battle_l, win_l, lose_l}) != 1) begin
                errors++;
                $display("FAIL onehot step %0d: got %b, expected one bit set",
                         i, {start_l, battle_l, win_l, lose_l});
            end
        end

        // Asynchronous reset in the middle of a BATTLE cycle.
        frame_start = 1'b0; start_key = 1'b0; player_hit = 1'b0; npc_hit = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        check_outputs(1000, rv);
        @(negedge Clk);
        Reset_n = 1'b1;
        rv.fs = 0; rv.sk = 0; rv.ph = 1; rv.nh = 1;
        apply(1001, rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
